// File: rtl/ecc_pkg.sv
// ecc_pkg: shared widths, scheduler states and point-unit opcodes for the kP scheduler
package ecc_pkg;
  localparam int DEF_SIZE = 32;
  localparam int DEF_NIB = 4;
  typedef enum logic [2:0] {IDLE, LOAD, SCAN, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, DONE} state_t;
  localparam logic OP_DBL = 1'b0;
  localparam logic OP_ADD = 1'b1;
endpackage

// File: rtl/ecc_nibble_loader.sv
// ecc_nibble_loader: deserialises five MSB-first nibble streams into SIZE-bit operands
// ports: clk/rst_n, en (high while loading), nib_* nibble inputs, a/p/k/px/py operands,
// load_done pulses on the cycle the last nibble is taken
module ecc_nibble_loader import ecc_pkg::*; #(
  parameter int SIZE = DEF_SIZE,
  parameter int NIB = DEF_NIB
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NIB-1:0]  nib_a,
  input  logic [NIB-1:0]  nib_p,
  input  logic [NIB-1:0]  nib_k,
  input  logic [NIB-1:0]  nib_x,
  input  logic [NIB-1:0]  nib_y,
  output logic [SIZE-1:0] a,
  output logic [SIZE-1:0] p,
  output logic [SIZE-1:0] k,
  output logic [SIZE-1:0] px,
  output logic [SIZE-1:0] py,
  output logic            load_done
);
  localparam int NIBBLES = SIZE / NIB;
  localparam int CW = $clog2(NIBBLES + 1);
  logic [CW-1:0] cnt;
  assign load_done = en && cnt == CW'(NIBBLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      a <= '0;
      p <= '0;
      k <= '0;
      px <= '0;
      py <= '0;
    end else if (en) begin
      cnt <= load_done ? '0 : cnt + 1'b1;
      a <= {a[SIZE-NIB-1:0], nib_a};
      p <= {p[SIZE-NIB-1:0], nib_p};
      k <= {k[SIZE-NIB-1:0], nib_k};
      px <= {px[SIZE-NIB-1:0], nib_x};
      py <= {py[SIZE-NIB-1:0], nib_y};
    end else
      cnt <= '0;
endmodule

// File: rtl/ecc_kp_scheduler.sv
// ecc_kp_scheduler: MSB-first double-and-add sequencer for kP over a shared point unit
// ports: i_clk/i_rst_n, i_start + operand nibbles in, o_op_* job request with i_op_ready,
// i_op_done/i_op_x/i_op_y/i_op_inf job result, o_kpx/o_kpy/o_kp_inf result, o_busy/o_done status
module ecc_kp_scheduler import ecc_pkg::*; #(
  parameter int SIZE = DEF_SIZE,
  parameter int NIB = DEF_NIB
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [NIB-1:0]  i_a,
  input  logic [NIB-1:0]  i_prime,
  input  logic [NIB-1:0]  i_k,
  input  logic [NIB-1:0]  i_px,
  input  logic [NIB-1:0]  i_py,
  output logic            o_op_valid,
  output logic            o_op_sel,
  output logic [SIZE-1:0] o_op_x1,
  output logic [SIZE-1:0] o_op_y1,
  output logic [SIZE-1:0] o_op_x2,
  output logic [SIZE-1:0] o_op_y2,
  output logic [SIZE-1:0] o_op_a,
  output logic [SIZE-1:0] o_op_p,
  input  logic            i_op_ready,
  input  logic            i_op_done,
  input  logic [SIZE-1:0] i_op_x,
  input  logic [SIZE-1:0] i_op_y,
  input  logic            i_op_inf,
  output logic [SIZE-1:0] o_kpx,
  output logic [SIZE-1:0] o_kpy,
  output logic            o_kp_inf,
  output logic            o_busy,
  output logic            o_done
);
  localparam int IW = $clog2(SIZE);
  state_t state, state_n;
  logic [SIZE-1:0] a, p, k, px, py, rx, ry, rx_n, ry_n;
  logic [IW-1:0] idx, idx_n, lead, eob_idx;
  logic r_inf, rinf_n, in_add, add_n, load_done, kbit, last, hit, end_bit;
  state_t eob_state;
  ecc_nibble_loader #(.SIZE(SIZE), .NIB(NIB)) u_load (
    .clk(i_clk), .rst_n(i_rst_n), .en(state == LOAD),
    .nib_a(i_a), .nib_p(i_prime), .nib_k(i_k), .nib_x(i_px), .nib_y(i_py),
    .a(a), .p(p), .k(k), .px(px), .py(py), .load_done(load_done)
  );
  always_comb begin
    lead = '0;
    for (int i = 0; i < SIZE; i++)
      if (k[i]) lead = IW'(i);
  end
  assign kbit = k[idx];
  assign last = idx == '0;
  assign eob_state = last ? DONE : DBL_REQ;
  assign eob_idx = last ? idx : idx - 1'b1;
  // a doubled result equal to P must be doubled again rather than sent to the adder
  assign hit = i_op_x == px && i_op_y == py;
  // the bit finishes after its doubling unless an addition still has to follow
  assign end_bit = in_add || !kbit || i_op_inf;
  assign o_op_valid = (state == DBL_REQ && !r_inf) || state == ADD_REQ;
  assign o_op_sel = state == ADD_REQ ? OP_ADD : OP_DBL;
  assign o_op_x1 = rx;
  assign o_op_y1 = ry;
  assign o_op_x2 = px;
  assign o_op_y2 = py;
  assign o_op_a = a;
  assign o_op_p = p;
  assign o_done = state == DONE;
  assign o_busy = (state != IDLE && state != DONE) || i_start;
  assign o_kp_inf = o_done && r_inf;
  assign o_kpx = o_done && !r_inf ? rx : '0;
  assign o_kpy = o_done && !r_inf ? ry : '0;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      rx <= '0;
      ry <= '0;
      r_inf <= 1'b0;
      idx <= '0;
      in_add <= 1'b0;
    end else begin
      state <= state_n;
      rx <= rx_n;
      ry <= ry_n;
      r_inf <= rinf_n;
      idx <= idx_n;
      in_add <= add_n;
    end
  always_comb begin
    state_n = state;
    rx_n = rx;
    ry_n = ry;
    rinf_n = r_inf;
    idx_n = idx;
    add_n = in_add;
    case (state)
      IDLE, DONE: if (i_start) state_n = LOAD;
      LOAD: if (load_done) state_n = SCAN;
      SCAN: begin
        rx_n = k == '0 ? '0 : px;
        ry_n = k == '0 ? '0 : py;
        rinf_n = k == '0;
        add_n = 1'b0;
        idx_n = lead == '0 ? '0 : lead - 1'b1;
        state_n = lead == '0 ? DONE : DBL_REQ;
      end
      DBL_REQ:
        if (r_inf) begin
          rx_n = kbit ? px : rx;
          ry_n = kbit ? py : ry;
          rinf_n = !kbit;
          state_n = eob_state;
          idx_n = eob_idx;
        end else if (i_op_ready)
          state_n = DBL_WAIT;
      DBL_WAIT:
        if (i_op_done) begin
          rx_n = !in_add && kbit && i_op_inf ? px : i_op_x;
          ry_n = !in_add && kbit && i_op_inf ? py : i_op_y;
          rinf_n = i_op_inf && (in_add || !kbit);
          add_n = !end_bit && hit;
          state_n = end_bit ? eob_state : hit ? DBL_REQ : ADD_REQ;
          idx_n = end_bit ? eob_idx : idx;
        end
      ADD_REQ: if (i_op_ready) state_n = ADD_WAIT;
      ADD_WAIT:
        if (i_op_done) begin
          rx_n = i_op_x;
          ry_n = i_op_y;
          rinf_n = i_op_inf;
          state_n = eob_state;
          idx_n = eob_idx;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ecc_kp_scheduler.sv
// tb_ecc_kp_scheduler: directed and randomized checks of kP against a repeated-addition model
`timescale 1ns/1ps
module tb_ecc_kp_scheduler;
  localparam int NIBBLES = 8;
  localparam int ORD = 19;
  localparam longint PRIME = 17;
  localparam longint CA = 2;
  localparam longint GX = 5;
  localparam longint GY = 1;
  logic clk = 0, rst_n = 0, start = 0, ready = 1, stray = 0;
  logic [3:0] na = 0, np = 0, nk = 0, nx = 0, ny = 0;
  logic op_valid, op_sel, kp_inf, busy, done;
  logic [31:0] op_x1, op_y1, op_x2, op_y2, op_a, op_p, kpx, kpy;
  logic u_done = 0, u_inf = 0;
  logic [31:0] u_x = 0, u_y = 0;
  int errors = 0, checks = 0;
  int njobs = 0, overlap = 0, vcyc = 0, pend = 0;
  logic [63:0] seq = 0;
  longint mx, my;
  bit mi;
  always #5 clk = ~clk;
  ecc_kp_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_a(na), .i_prime(np), .i_k(nk), .i_px(nx), .i_py(ny),
    .o_op_valid(op_valid), .o_op_sel(op_sel),
    .o_op_x1(op_x1), .o_op_y1(op_y1), .o_op_x2(op_x2), .o_op_y2(op_y2),
    .o_op_a(op_a), .o_op_p(op_p), .i_op_ready(ready),
    .i_op_done(u_done | stray), .i_op_x(u_x), .i_op_y(u_y), .i_op_inf(u_inf),
    .o_kpx(kpx), .o_kpy(kpy), .o_kp_inf(kp_inf), .o_busy(busy), .o_done(done)
  );
  function automatic longint md(input longint v, input longint p);
    return ((v % p) + p) % p;
  endfunction
  function automatic longint inv(input longint v, input longint p);
    longint r = 1, b = md(v, p), e = p - 2;
    while (e > 0) begin
      if (e[0]) r = md(r * b, p);
      b = md(b * b, p);
      e = e >> 1;
    end
    return r;
  endfunction
  function automatic void padd(input longint x1, input longint y1, input bit i1,
                               input longint x2, input longint y2, input bit i2,
                               input longint a, input longint p,
                               output longint xr, output longint yr, output bit ir);
    longint l;
    xr = 0; yr = 0; ir = 0;
    if (i1) begin xr = x2; yr = y2; ir = i2; end
    else if (i2) begin xr = x1; yr = y1; end
    else if (x1 == x2 && md(y1 + y2, p) == 0) ir = 1;
    else begin
      l = x1 == x2 ? md(md(3 * x1 * x1 + a, p) * inv(2 * y1, p), p)
                   : md(md(y2 - y1, p) * inv(x2 - x1, p), p);
      xr = md(l * l - x1 - x2, p);
      yr = md(l * (x1 - xr) - y1, p);
    end
  endfunction
  // kP as k repeated additions of P in a group of order 19
  function automatic void mul(input longint k, input longint bx, input longint by,
                              output longint ex, output longint ey, output bit ei);
    longint tx, ty;
    bit ti;
    ex = 0; ey = 0; ei = 1;
    for (longint n = 0; n < k % ORD; n++) begin
      padd(ex, ey, ei, bx, by, 0, CA, PRIME, tx, ty, ti);
      ex = tx; ey = ty; ei = ti;
    end
    if (ei) begin ex = 0; ey = 0; end
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= 0;
      u_done <= 0;
    end else begin
      u_done <= pend == 1;
      if (pend != 0) pend <= pend - 1;
      if (op_valid && ready) begin
        if (pend != 0) overlap <= overlap + 1;
        if (op_sel) padd(op_x1, op_y1, 0, op_x2, op_y2, 0, op_a, op_p, mx, my, mi);
        else padd(op_x1, op_y1, 0, op_x1, op_y1, 0, op_a, op_p, mx, my, mi);
        u_x <= 32'(mx);
        u_y <= 32'(my);
        u_inf <= mi;
        pend <= 3;
        njobs <= njobs + 1;
        seq <= {seq[62:0], op_sel};
      end
    end
  always @(negedge clk) vcyc <= vcyc + (op_valid ? 1 : 0);
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start_load(input logic [31:0] k, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a32, p32;
    a32 = 32'(CA);
    p32 = 32'(PRIME);
    @(negedge clk);
    start = 1;
    for (int i = NIBBLES - 1; i >= 0; i--) begin
      @(negedge clk);
      start = 0;
      na = a32[i*4 +: 4];
      np = p32[i*4 +: 4];
      nk = k[i*4 +: 4];
      nx = x[i*4 +: 4];
      ny = y[i*4 +: 4];
      if (i == NIBBLES - 1) chk("load_status", {busy, done}, 2'b10);
    end
  endtask
  task automatic wait_done(input bit rnd, output int cyc);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    ready = 1;
    chk("done_timeout", cyc < 3000, 1);
    chk("done_status", {busy, done}, 2'b01);
  endtask
  task automatic chk_res(input string tag, input longint ex, input longint ey, input bit ei);
    chk(tag, {kp_inf, kpx, kpy}, {ei, 32'(ex), 32'(ey)});
  endtask
  initial begin
    int cyc, base, v0;
    longint ex, ey, bx, by;
    bit ei;
    logic [31:0] kr;
    logic [192:0] snap;
    repeat (2) @(negedge clk);
    chk("reset_outs", {op_valid, op_sel, op_x1, op_y1, op_x2, op_y2, op_a, op_p, kpx, kpy, kp_inf, busy, done}, '0);
    rst_n = 1;
    @(negedge clk);
    base = njobs; v0 = vcyc;
    start_load(0, 32'(GX), 32'(GY));
    wait_done(0, cyc);
    chk("k0_latency", cyc <= 2, 1);
    chk_res("k0_result", 0, 0, 1);
    chk("k0_valid_cycles", vcyc - v0, 0);
    base = njobs;
    start_load(1, 32'(GX), 32'(GY));
    wait_done(0, cyc);
    chk_res("k1_result", 5, 1, 0);
    chk("k1_jobs", njobs - base, 0);
    chk("a_p_loaded", {op_a, op_p}, {32'd2, 32'd17});
    base = njobs;
    start_load(7, 32'(GX), 32'(GY));
    wait_done(0, cyc);
    chk_res("k7_result", 0, 6, 0);
    chk("k7_jobs", {njobs - base, seq[3:0]}, {32'd4, 4'b0101});
    base = njobs;
    start_load(21, 32'(GX), 32'(GY));
    wait_done(0, cyc);
    chk_res("k21_result", 6, 3, 0);
    chk("k21_jobs", {njobs - base, seq[5:0]}, {32'd6, 6'b001000});
    base = njobs;
    start_load(39, 32'(GX), 32'(GY));
    wait_done(0, cyc);
    chk_res("k39_result", 5, 1, 0);
    chk("k39_jobs", {njobs - base, seq[5:0]}, {32'd6, 6'b000101});
    base = njobs;
    start_load(7, 32'(GX), 32'(GY));
    cyc = 0;
    while (njobs < base + 1 && cyc < 200) begin @(negedge clk); cyc++; end
    ready = 0;
    while (!op_valid && cyc < 200) begin @(negedge clk); cyc++; end
    chk("stall_reach", cyc < 200, 1);
    snap = {op_sel, op_x1, op_y1, op_x2, op_y2, op_a, op_p};
    for (int i = 0; i < 5; i++) begin
      start = i == 2;
      @(negedge clk);
      chk("stall_valid", {op_valid, busy}, 2'b11);
      chk("stall_operands", {op_sel, op_x1, op_y1, op_x2, op_y2, op_a, op_p}, snap);
    end
    start = 0;
    ready = 1;
    wait_done(0, cyc);
    chk_res("stall_result", 0, 6, 0);
    chk("stall_jobs", {njobs - base, seq[3:0]}, {32'd4, 4'b0101});
    base = njobs;
    start_load(7, 32'(GX), 32'(GY));
    cyc = 0;
    while (njobs < base + 2 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("rst_reach", cyc < 200, 1);
    #2 rst_n = 0;
    #1 chk("async_reset_outs", {op_valid, op_sel, op_x1, op_y1, op_x2, op_y2, op_a, op_p, kpx, kpy, kp_inf, busy, done}, '0);
    @(negedge clk);
    rst_n = 1;
    base = njobs;
    @(negedge clk);
    stray = 1;
    @(negedge clk);
    stray = 0;
    repeat (2) @(negedge clk);
    chk("stray_done_ignored", {op_valid, busy, done, njobs - base}, '0);
    base = njobs;
    start_load(7, 32'(GX), 32'(GY));
    wait_done(0, cyc);
    chk_res("post_reset_result", 0, 6, 0);
    for (int t = 0; t < 8; t++) begin
      mul($urandom_range(1, ORD - 1), GX, GY, bx, by, ei);
      kr = t[0] ? 32'($urandom) : 32'($urandom_range(0, 45));
      start_load(kr, 32'(bx), 32'(by));
      wait_done(1, cyc);
      mul(longint'(kr), bx, by, ex, ey, ei);
      chk("random_result", {kr, kp_inf, kpx, kpy}, {kr, ei, 32'(ex), 32'(ey)});
    end
    chk("one_job_outstanding", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ecc_kp_scheduler.md
Name: ecc_kp_scheduler

Overview:
- Sequences scalar multiplication kP for the ECC core using MSB-first double-and-add.
- Deserialises the nibble-serial operand stream (a, prime, k, Px, Py), then issues point-double and point-add jobs to one shared point-arithmetic unit over a valid/ready request and done-pulse return.
- Returns kPx/kPy plus an infinity flag, and asserts a done level. Sits between the top-level nibble interface and the point unit.

Parameters:
- SIZE, 32, field/scalar width in bits.
- NIB, 4, input nibble width. Localparam NIBBLES = SIZE/NIB. SIZE must be a multiple of NIB.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start strobe, one cycle, carries no data.
- i_a, i_prime, i_k, i_px, i_py  in  NIB each  operand nibbles, MSB nibble first.
- o_op_valid  out  1  job request.
- o_op_sel  out  1  0 = DBL(x1,y1), 1 = ADD(x1,y1)+(x2,y2).
- o_op_x1, o_op_y1, o_op_x2, o_op_y2, o_op_a, o_op_p  out  SIZE each  job operands.
- i_op_ready  in  1  unit accepts the job when o_op_valid && i_op_ready at a rising edge.
- i_op_done  in  1  one-cycle result strobe.
- i_op_x, i_op_y  in  SIZE each  result coordinates.
- i_op_inf  in  1  result is the point at infinity.
- o_kpx, o_kpy  out  SIZE each  result coordinates.
- o_kp_inf  out  1  result is infinity.
- o_busy  out  1  high from the i_start cycle until DONE.
- o_done  out  1  level, high in DONE.

Behaviour:
- Reset (async, i_rst_n low): state IDLE. All outputs 0 and all internal registers 0.
- IDLE: i_start=1 -> LOAD, nibble counter = 0.
- LOAD: each cycle shift one nibble of every operand in, MSB first. After NIBBLES cycles -> SCAN. Load length is 1 + NIBBLES cycles (9 cycles at defaults).
- SCAN: bit index idx = position of the leading 1 of k.
  - k = 0 -> DONE, result inf, (0,0). No jobs are issued.
  - Otherwise R = (Px,Py), R_inf = 0, idx = idx-1. If no bits remain -> DONE.
  - Scanning may be iterative (at most 1 bit per cycle) or a combinational priority encoder. Either way no op_valid is asserted during SCAN.
- DBL phase for bit idx:
  - If R_inf, skip (R stays inf).
  - Otherwise DBL_REQ: assert o_op_valid, o_op_sel=0, x1/y1=R. Hold valid and all operands stable until ready.
  - Then DBL_WAIT until i_op_done; latch R = (i_op_x, i_op_y, i_op_inf).
- ADD phase, only if k[idx]=1:
  - If R_inf: R = P with no job.
  - Else if R == P (coords equal): issue DBL of R (o_op_sel=0).
  - Else ADD_REQ/ADD_WAIT with x2/y2 = P.
  - i_op_inf from the unit covers the R = -P case.
- After each bit: idx = 0 -> DONE, else idx = idx-1 -> DBL phase.
- DONE:
  - o_done=1 and o_busy=0.
  - o_kpx/o_kpy = R, or 0 if inf. o_kp_inf = R_inf.
  - Outputs hold until the next i_start or reset.
  - i_start in DONE -> LOAD, with o_done dropping the next cycle.
- i_start while busy is ignored.
- i_op_done outside a *_WAIT state is ignored.
- o_op_a = a and o_op_p = prime, constant after LOAD.
- Reset mid-operation abandons the in-flight job. The bench must also reset the point unit.
- At most one job outstanding at any time.

Decomposition:
- Shared package ecc_pkg:
  - SIZE/NIB defaults.
  - State enum: IDLE, LOAD, SCAN, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, DONE.
  - OP_DBL=0 and OP_ADD=1 constants.
- Sub-module ecc_nibble_loader: shift registers plus nibble counter, producing a load_done pulse. The FSM stays in the top block.

Test Plan:
- Common setup for all scenarios: curve y^2=x^3+2x+2 mod 17, P=(5,1), behavioural point-unit model with 3-cycle latency and ready always high unless stated.
- k=0 -> done with inf=1, x=y=0. Zero op_valid cycles. o_done high by load+2 cycles.
- k=1 -> (5,1), inf=0, zero jobs issued.
- k=7 -> job sequence DBL,ADD,DBL,ADD. Result (0,6).
- k=21 -> sequence DBL,DBL,ADD,DBL,DBL,DBL (last is the R==P collision issued as DBL). Result (6,3).
- k=39 -> sequence D,D,D,A,D,A. Then the last bit's DBL is skipped and ADD becomes R=P with no job. Result (5,1), inf=0.
- k=7 with i_op_ready low for 5 cycles on the 2nd job, plus i_start pulsed mid-run:
  - operands stay stable while valid is held
  - the stray i_start is ignored
  - result is (0,6)
- i_rst_n low during ADD_WAIT of k=7:
  - all outputs go 0 asynchronously
  - the late i_op_done is ignored
  - a fresh k=7 run returns (0,6)
